fft_frame_sequencer: RTL and testbench

//  Sequences FFT frames between the input sample queue and the AXI-Stream FFT core.
//  Per frame: issues one FFT config word, then passes exactly FRAME_LEN queue beats to the FFT data channel.

---
 rtl/fft_seq_pkg.sv | 15 +
 rtl/fft_cfg_packer.sv | 19 +
 rtl/fft_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame sequencer: FSM state encoding and
// bit offsets of the fields inside the FFT config word.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    localparam int FWD_INV_BIT = 0;
    localparam int SCALE_LSB   = 1;

endpackage

// File: rtl/fft_cfg_packer.sv
// Packs the FFT config word: {zero pad, scale_sch, fwd_inv}.
module fft_cfg_packer
    import fft_seq_pkg::*;
#(
    parameter int SCALE_W = 12,
    parameter int CFG_W   = 16
) (
    input  logic               fwd_inv,
    input  logic [SCALE_W-1:0] scale_sch,
    output logic [CFG_W-1:0]   cfg_tdata
);

    always_comb begin
        cfg_tdata                       = '0;
        cfg_tdata[FWD_INV_BIT]          = fwd_inv;
        cfg_tdata[SCALE_LSB +: SCALE_W] = scale_sch;
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Sequences FFT frames: one config beat, then exactly FRAME_LEN data beats.
// Define FFT_SEQ_STATS_EN to add the frame_count / err_count statistics outputs.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 4096,
    parameter int SCALE_W   = 12,
    parameter int CFG_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               fwd_inv,
    input  logic [SCALE_W-1:0] scale_sch,
    output logic [CFG_W-1:0]   cfg_tdata,
    output logic               cfg_tvalid,
    input  logic               cfg_tready,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               err_last
`ifdef FFT_SEQ_STATS_EN
    ,
    output logic [31:0]        frame_count,
    output logic [15:0]        err_count
`endif
);

    localparam int               CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    seq_state_t         state, state_nxt;
    logic               fwd_inv_q;
    logic [SCALE_W-1:0] scale_sch_q;
    logic [CNT_W-1:0]   beat_cnt;
    logic               final_beat;
    logic               xfer;
    logic               misaligned;
    logic               start_cfg;

    fft_cfg_packer #(
        .SCALE_W (SCALE_W),
        .CFG_W   (CFG_W)
    ) u_cfg_packer (
        .fwd_inv   (fwd_inv_q),
        .scale_sch (scale_sch_q),
        .cfg_tdata (cfg_tdata)
    );

    // Reset gates the beat qualifiers so nothing completes on the reset edge.
    assign final_beat = (beat_cnt == LAST_BEAT);
    assign xfer       = !reset && (state == STREAM) && s_valid && m_ready;
    assign misaligned = xfer && (s_last != final_beat);
    assign start_cfg  = enable && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = CONFIG;
            CONFIG:  if (cfg_tready) state_nxt = STREAM;
            STREAM:  if (xfer && final_beat) state_nxt = DONE;
            DONE:    state_nxt = enable ? CONFIG : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_tvalid = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        frame_done = 1'b0;
        if (!reset) begin
            case (state)
                CONFIG: cfg_tvalid = 1'b1;
                STREAM: begin
                    m_data  = s_data;
                    m_valid = s_valid;
                    s_ready = m_ready;
                    m_last  = final_beat;
                end
                DONE:    frame_done = 1'b1;
                default: ;
            endcase
        end
    end

    // Beat counter wraps naturally to 0 on the final beat of each frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt    <= '0;
            fwd_inv_q   <= 1'b0;
            scale_sch_q <= '0;
            err_last    <= 1'b0;
        end else begin
            if (start_cfg) begin
                fwd_inv_q   <= fwd_inv;
                scale_sch_q <= scale_sch;
            end
            if (xfer)
                beat_cnt <= beat_cnt + CNT_W'(1);
            if (misaligned)
                err_last <= 1'b1;
        end
    end

`ifdef FFT_SEQ_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (state == DONE)
                frame_count <= frame_count + 32'd1;
            if (misaligned && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (FRAME_LEN=16, SCALE_W=4, CFG_W=8).
module tb_fft_frame_sequencer;

    localparam int DATA_W    = 12;
    localparam int FRAME_LEN = 16;
    localparam int SCALE_W   = 4;
    localparam int CFG_W     = 8;

    logic               clock = 1'b0;
    logic               reset, enable, fwd_inv;
    logic [SCALE_W-1:0] scale_sch;
    logic [CFG_W-1:0]   cfg_tdata;
    logic               cfg_tvalid, cfg_tready;
    logic [DATA_W-1:0]  s_data, m_data;
    logic               s_valid, s_last, s_ready;
    logic               m_valid, m_last, m_ready;
    logic               busy, frame_done, err_last;
`ifdef FFT_SEQ_STATS_EN
    logic [31:0]        frame_count;
    logic [15:0]        err_count;
`endif

    always #5 clock = ~clock;

    fft_frame_sequencer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .SCALE_W   (SCALE_W),
        .CFG_W     (CFG_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .fwd_inv    (fwd_inv),
        .scale_sch  (scale_sch),
        .cfg_tdata  (cfg_tdata),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .err_last   (err_last)
`ifdef FFT_SEQ_STATS_EN
        ,
        .frame_count (frame_count),
        .err_count   (err_count)
`endif
    );

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor, sampled mid low phase while inputs are stable.
    logic [CFG_W-1:0]  cq[$];
    logic [DATA_W-1:0] dq[$];
    bit                lq[$];
    int                ndone = 0;
    int                done_seen = 0;

    always @(negedge clock) begin
        #2;
        if (cfg_tvalid && cfg_tready) cq.push_back(cfg_tdata);
        if (m_valid && m_ready) begin
            dq.push_back(m_data);
            lq.push_back(m_last);
        end
        if (frame_done) ndone++;
    end

    // Queue source: beat i carries base+i, s_last on every 16th beat and on bad_last.
    task automatic feed(input int nbeats, input int base, input int bad_last,
                        input int drop_at, input int abort_at, input bit stall);
        int i;
        int guard;
        bit err_next;
        bit xs;
        i = 0; guard = 0; err_next = 0;
        while (i < nbeats) begin
            @(negedge clock);
            if (err_next) begin
                chk("err_last_rise", err_last, 1);
                err_next = 0;
            end
            if (i == abort_at) return;
            guard++;
            if (guard > 2000) begin
                chk("feed_timeout", i, nbeats);
                s_valid = 0;
                return;
            end
            if (drop_at >= 0 && i >= drop_at) enable = 0;
            s_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = DATA_W'(base + i);
            s_last  = ((i % FRAME_LEN) == FRAME_LEN - 1) || (i == bad_last);
            #1;
            xs = s_valid && s_ready;
            if (xs && i == bad_last) begin
                chk("err_last_pre", err_last, 0);
                err_next = 1;
            end
            @(posedge clock);
            if (xs) i++;
        end
        @(negedge clock);
        s_valid = 0;
        s_last  = 0;
    endtask

    task automatic check_frames(input string tag, input int base, input int n,
                                input logic [CFG_W-1:0] cw);
        int bc, bd, bl;
        bit lx;
        bc = 0; bd = 0; bl = 0;
        chk({tag, " cfg_beats"}, cq.size(), n);
        chk({tag, " data_beats"}, dq.size(), n * FRAME_LEN);
        chk({tag, " frame_done"}, ndone - done_seen, n);
        done_seen = ndone;
        while (cq.size() > 0) if (cq.pop_front() !== cw) bc++;
        for (int k = 0; k < n * FRAME_LEN && dq.size() > 0; k++) begin
            if (dq.pop_front() !== DATA_W'(base + k)) bd++;
            lx = lq.pop_front();
            if (lx != ((k % FRAME_LEN) == FRAME_LEN - 1)) bl++;
        end
        chk({tag, " cfg_word"}, bc, 0);
        chk({tag, " data_order"}, bd, 0);
        chk({tag, " m_last_pos"}, bl, 0);
        dq.delete();
        lq.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; enable = 0; fwd_inv = 0; scale_sch = '0; cfg_tready = 0;
        s_data = '0; s_valid = 0; s_last = 0; m_ready = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        m_ready = 1;
        #1;
        chk("rst cfg_tvalid", cfg_tvalid, 0);
        chk("rst cfg_tdata", cfg_tdata, 0);
        chk("rst s_ready", s_ready, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst m_last", m_last, 0);
        chk("rst busy", busy, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst err_last", err_last, 0);

        // 1: single frame, immediate config handshake
        @(negedge clock);
        enable = 1; fwd_inv = 1; scale_sch = 4'hA; cfg_tready = 1;
        feed(FRAME_LEN, 'h100, -1, 0, -1, 0);
        repeat (2) @(negedge clock);
        check_frames("t1", 'h100, 1, 8'h15);
        chk("t1 busy_idle", busy, 0);

        // 2: config stalled by cfg_tready for 5 cycles
        enable = 1; fwd_inv = 0; scale_sch = 4'h3; cfg_tready = 0;
        repeat (5) begin
            @(negedge clock);
            enable = 0; s_valid = 1; m_ready = 1;
            #1;
            chk("t2 cfg_tvalid", cfg_tvalid, 1);
            chk("t2 cfg_tdata", cfg_tdata, 8'h06);
            chk("t2 s_ready", s_ready, 0);
            chk("t2 m_valid", m_valid, 0);
        end
        cfg_tready = 1;
        feed(FRAME_LEN, 'h200, -1, 0, -1, 0);
        repeat (2) @(negedge clock);
        check_frames("t2", 'h200, 1, 8'h06);

        // 3: back-to-back frames with random stalls
        enable = 1; fwd_inv = 1; scale_sch = 4'h5;
        feed(3 * FRAME_LEN, 'h300, -1, 40, -1, 1);
        repeat (2) @(negedge clock);
        check_frames("t3", 'h300, 3, 8'h0B);
        chk("t3 err_last", err_last, 0);

        // 4: early s_last on beat 9
        enable = 1; fwd_inv = 1; scale_sch = 4'hA; m_ready = 1;
        feed(FRAME_LEN, 'h400, 9, 0, -1, 0);
        repeat (2) @(negedge clock);
        check_frames("t4", 'h400, 1, 8'h15);
        chk("t4 err_last_sticky", err_last, 1);
`ifdef FFT_SEQ_STATS_EN
        chk("t4 frame_count", frame_count, 6);
        chk("t4 err_count", err_count, 1);
`endif

        // 5: enable dropped at beat 3
        enable = 1; fwd_inv = 0; scale_sch = 4'hF;
        feed(FRAME_LEN, 'h500, -1, 3, -1, 0);
        #1;
        chk("t5 done_pulse", frame_done, 1);
        chk("t5 busy_done", busy, 1);
        @(negedge clock);
        #1;
        chk("t5 busy_after", busy, 0);
        chk("t5 cfg_idle", cfg_tvalid, 0);
        @(negedge clock);
        check_frames("t5", 'h500, 1, 8'h1E);

        // 6: reset at beat 7, then a clean frame
        enable = 1; fwd_inv = 1; scale_sch = 4'hA;
        feed(FRAME_LEN, 'h600, -1, 0, 7, 0);
        reset = 1;
        #1;
        chk("t6 rst_m_valid", m_valid, 0);
        chk("t6 rst_s_ready", s_ready, 0);
        @(negedge clock);
        reset = 0; s_valid = 0;
        #1;
        chk("t6 busy", busy, 0);
        chk("t6 err_last", err_last, 0);
        chk("t6 m_last", m_last, 0);
        chk("t6 cfg_tvalid", cfg_tvalid, 0);
        chk("t6 cfg_tdata", cfg_tdata, 0);
        chk("t6 frame_done", frame_done, 0);
`ifdef FFT_SEQ_STATS_EN
        chk("t6 frame_count", frame_count, 0);
        chk("t6 err_count", err_count, 0);
`endif
        cq.delete(); dq.delete(); lq.delete();
        done_seen = ndone;
        @(negedge clock);
        enable = 1;
        feed(FRAME_LEN, 'h700, -1, 0, -1, 0);
        repeat (2) @(negedge clock);
        check_frames("t6 restart", 'h700, 1, 8'h15);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
